// File: rtl/mbtrain_cal_tx_seq.sv
// rtl/mbtrain_cal_tx_seq.sv - mainband training TX calibration sequencer
// Handshakes start/end with the partner over sideband, runs the point test with bounded retries.
module mbtrain_cal_tx_seq #(
  parameter int          NUM_LANES      = 16,
  parameter bit          MODE           = 1'b0,
  parameter logic [3:0]  MSG_START_REQ  = 4'd1,
  parameter logic [3:0]  MSG_START_RESP = 4'd2,
  parameter logic [3:0]  MSG_END_REQ    = 4'd3,
  parameter logic [3:0]  MSG_END_RESP   = 4'd4,
  parameter int          TIMEOUT_CYCLES = 1024,
  parameter int          MAX_RETRY      = 2,
  localparam int         RETRY_W        = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 i_en,
  input  logic [3:0]           i_decoded_sideband_message,
  input  logic                 i_sideband_valid,
  input  logic                 i_busy_negedge_detected,
  input  logic                 i_valid_rx,
  input  logic                 i_test_ack,
  input  logic [NUM_LANES-1:0] i_rx_lanes_result,
  input  logic [NUM_LANES-1:0] i_lane_mask,
  output logic [3:0]           o_sideband_message,
  output logic                 o_valid_tx,
  output logic                 o_pt_en,
  output logic                 o_mainband_or_valtrain_test,
  output logic                 o_test_ack,
  output logic                 o_error,
  output logic                 o_pass,
  output logic [NUM_LANES-1:0] o_lanes_result,
  output logic [RETRY_W-1:0]   o_retry_cnt
);

  localparam int TIMER_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    START_REQ = 3'd1,
    CAL_ALGO  = 3'd2,
    EVAL      = 3'd3,
    END_REQ   = 3'd4,
    DONE      = 3'd5,
    ERROR     = 3'd6
  } state_t;

  state_t               cs, ns;
  logic [TIMER_W-1:0]   timer;
  logic                 start_resp, end_resp, timeout, pass, retry_max, abort;

  assign start_resp = i_sideband_valid && (i_decoded_sideband_message == MSG_START_RESP);
  assign end_resp   = i_sideband_valid && (i_decoded_sideband_message == MSG_END_RESP);
  assign timeout    = (timer == TIMER_W'(TIMEOUT_CYCLES - 1));
  assign pass       = &(o_lanes_result | i_lane_mask);
  assign retry_max  = (o_retry_cnt == RETRY_W'(MAX_RETRY));
  assign abort      = (cs != IDLE) && !i_en;

  // Timer only runs while waiting on the partner and restarts on every state change.
  always_ff @(posedge clk) begin
    if (rst) begin
      cs    <= IDLE;
      timer <= '0;
    end else begin
      cs <= ns;
      if ((ns != cs) || !((cs == START_REQ) || (cs == END_REQ)))
        timer <= '0;
      else
        timer <= timer + 1'b1;
    end
  end

  always_comb begin
    ns = cs;
    if (abort) begin
      ns = IDLE;
    end else begin
      case (cs)
        IDLE:      if (i_en) ns = START_REQ;
        START_REQ: if (start_resp) ns = CAL_ALGO;
                   else if (timeout) ns = ERROR;
        CAL_ALGO:  if (i_test_ack) ns = EVAL;
        EVAL:      ns = (pass || retry_max) ? END_REQ : CAL_ALGO;
        END_REQ:   if (end_resp) ns = DONE;
                   else if (timeout) ns = ERROR;
        DONE:      ns = DONE;
        ERROR:     ns = ERROR;
        default:   ns = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      o_sideband_message          <= '0;
      o_valid_tx                  <= 1'b0;
      o_pt_en                     <= 1'b0;
      o_mainband_or_valtrain_test <= 1'b0;
      o_test_ack                  <= 1'b0;
      o_error                     <= 1'b0;
      o_pass                      <= 1'b0;
      o_lanes_result              <= '0;
      o_retry_cnt                 <= '0;
    end else if (abort) begin
      o_sideband_message          <= '0;
      o_valid_tx                  <= 1'b0;
      o_pt_en                     <= 1'b0;
      o_mainband_or_valtrain_test <= 1'b0;
      o_test_ack                  <= 1'b0;
      o_error                     <= 1'b0;
      o_pass                      <= 1'b0;
      o_retry_cnt                 <= '0;
    end else begin
      if (i_busy_negedge_detected && !i_valid_rx)
        o_valid_tx <= 1'b0;
      if ((ns != cs) && ((ns == START_REQ) || (ns == END_REQ)))
        o_valid_tx <= 1'b1;

      case (cs)
        IDLE: begin
          if (i_en) begin
            o_sideband_message <= MSG_START_REQ;
            o_retry_cnt        <= '0;
            o_pass             <= 1'b0;
            o_test_ack         <= 1'b0;
            o_error            <= 1'b0;
          end
        end
        START_REQ, END_REQ: begin
          if (ns == CAL_ALGO) begin
            o_pt_en                     <= 1'b1;
            o_mainband_or_valtrain_test <= MODE;
          end else if (ns == DONE) begin
            o_sideband_message <= '0;
            o_test_ack         <= 1'b1;
          end else if (ns == ERROR) begin
            o_error            <= 1'b1;
            o_pt_en            <= 1'b0;
            o_sideband_message <= '0;
            o_valid_tx         <= 1'b0;
          end
        end
        CAL_ALGO: begin
          if (i_test_ack) begin
            o_lanes_result <= i_rx_lanes_result;
            o_pt_en        <= 1'b0;
          end
        end
        EVAL: begin
          o_pass <= pass;
          if (ns == END_REQ) begin
            o_sideband_message <= MSG_END_REQ;
          end else begin
            o_retry_cnt <= o_retry_cnt + 1'b1;
            o_pt_en     <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mbtrain_cal_tx_seq.sv
// tb/tb_mbtrain_cal_tx_seq.sv - self-checking bench for mbtrain_cal_tx_seq
// Transaction-phase reference model, directed scenarios plus randomized traffic.
module tb_mbtrain_cal_tx_seq;

  localparam int NL   = 16;
  localparam int TMO  = 1024;
  localparam int MAXR = 2;
  localparam bit MD   = 1'b1;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          en = 1'b0;
  logic [3:0]    msg = 4'd0;
  logic          sv = 1'b0;
  logic          busy = 1'b0;
  logic          vrx = 1'b0;
  logic          ack = 1'b0;
  logic [NL-1:0] res = '0;
  logic [NL-1:0] mask = '0;

  logic [3:0]    o_msg;
  logic          o_vtx, o_pt, o_mb, o_tack, o_err, o_pass;
  logic [NL-1:0] o_lanes;
  logic [1:0]    o_retry;

  mbtrain_cal_tx_seq #(.NUM_LANES(NL), .MODE(MD), .TIMEOUT_CYCLES(TMO), .MAX_RETRY(MAXR)) dut (
    .clk(clk), .rst(rst), .i_en(en),
    .i_decoded_sideband_message(msg), .i_sideband_valid(sv),
    .i_busy_negedge_detected(busy), .i_valid_rx(vrx),
    .i_test_ack(ack), .i_rx_lanes_result(res), .i_lane_mask(mask),
    .o_sideband_message(o_msg), .o_valid_tx(o_vtx), .o_pt_en(o_pt),
    .o_mainband_or_valtrain_test(o_mb), .o_test_ack(o_tack), .o_error(o_err),
    .o_pass(o_pass), .o_lanes_result(o_lanes), .o_retry_cnt(o_retry)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  bit chk_on = 1'b0;
  int pt_rises = 0;
  logic pt_prev = 1'b0;

  // Model phases: 0 idle, 1 awaiting start resp, 2 test running, 3 judging,
  // 4 awaiting end resp, 5 finished, 6 failed.
  int ph = 0;
  int waited = 0;
  logic [3:0]    e_msg = 0;
  logic          e_vtx = 0, e_pt = 0, e_mb = 0, e_tack = 0, e_err = 0, e_pass = 0;
  logic [NL-1:0] e_lanes = 0;
  int            e_retry = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      if (errors <= 30) $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic clear_model(input bit keep_lanes);
    e_msg = 0; e_vtx = 0; e_pt = 0; e_mb = 0; e_tack = 0; e_err = 0; e_pass = 0; e_retry = 0;
    if (!keep_lanes) e_lanes = 0;
    ph = 0; waited = 0;
  endtask

  task automatic model_step();
    logic [3:0] want;
    bit ok;
    if (rst) begin clear_model(1'b0); return; end
    if (!en && ph != 0) begin clear_model(1'b1); return; end
    if (busy && !vrx) e_vtx = 0;
    case (ph)
      0: if (en) begin
        ph = 1; waited = 0; e_msg = 4'd1; e_vtx = 1;
        e_retry = 0; e_pass = 0; e_tack = 0; e_err = 0;
      end
      1, 4: begin
        waited++;
        want = (ph == 1) ? 4'd2 : 4'd4;
        if (sv && msg == want) begin
          if (ph == 1) begin ph = 2; e_pt = 1; e_mb = MD; end
          else begin ph = 5; e_msg = 0; e_tack = 1; end
        end else if (waited == TMO) begin
          ph = 6; e_err = 1; e_pt = 0; e_msg = 0; e_vtx = 0;
        end
      end
      2: if (ack) begin e_lanes = res; e_pt = 0; ph = 3; end
      3: begin
        ok = ((e_lanes | mask) == {NL{1'b1}});
        e_pass = ok;
        if (ok || e_retry == MAXR) begin
          ph = 4; waited = 0; e_msg = 4'd3; e_vtx = 1;
        end else begin
          e_retry++; e_pt = 1; ph = 2;
        end
      end
      default: ;
    endcase
  endtask

  task automatic cyc();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic send(input logic [3:0] code);
    sv = 1; msg = code; cyc(); sv = 0; msg = 0;
  endtask

  task automatic run_pt(input logic [NL-1:0] r);
    res = r; ack = 1; cyc(); ack = 0; cyc();
  endtask

  task automatic go_idle();
    en = 0; cyc(); cyc();
  endtask

  initial forever begin
    @(negedge clk);
    if (o_pt && !pt_prev) pt_rises++;
    pt_prev = o_pt;
    if (chk_on) begin
      chk("msg", 32'(o_msg), 32'(e_msg));
      chk("valid_tx", 32'(o_vtx), 32'(e_vtx));
      chk("pt_en", 32'(o_pt), 32'(e_pt));
      chk("mb_test", 32'(o_mb), 32'(e_mb));
      chk("test_ack", 32'(o_tack), 32'(e_tack));
      chk("error", 32'(o_err), 32'(e_err));
      chk("pass", 32'(o_pass), 32'(e_pass));
      chk("lanes", 32'(o_lanes), 32'(e_lanes));
      chk("retry", 32'(o_retry), 32'(e_retry));
    end
  end

  initial begin
    rst = 1; en = 1;
    cyc(); cyc();
    chk_on = 1;
    chk("rst_msg", 32'(o_msg), 32'd0);
    chk("rst_vtx", 32'(o_vtx), 32'd0);
    chk("rst_err", 32'(o_err), 32'd0);
    rst = 0; en = 0; cyc();

    // nominal handshake
    en = 1; cyc();
    chk("nom_start_msg", 32'(o_msg), 32'd1);
    chk("nom_start_vtx", 32'(o_vtx), 32'd1);
    cyc(); cyc();
    send(4'd2);
    chk("nom_pt_en", 32'(o_pt), 32'd1);
    chk("nom_mb", 32'(o_mb), 32'd1);
    run_pt(16'hFFFF);
    chk("nom_end_msg", 32'(o_msg), 32'd3);
    chk("nom_pass", 32'(o_pass), 32'd1);
    busy = 1; cyc(); busy = 0;
    chk("nom_vtx_clear", 32'(o_vtx), 32'd0);
    send(4'd4);
    chk("nom_tack", 32'(o_tack), 32'd1);
    chk("nom_retry", 32'(o_retry), 32'd0);
    chk("nom_done_msg", 32'(o_msg), 32'd0);
    go_idle();

    // retry until pass on third run
    en = 1; cyc(); send(4'd2);
    pt_rises = 0;
    run_pt(16'hFFFE); run_pt(16'hFFFE); run_pt(16'hFFFF);
    chk("retry_pulses", 32'(pt_rises), 32'd3);
    chk("retry_cnt", 32'(o_retry), 32'd2);
    chk("retry_pass", 32'(o_pass), 32'd1);
    chk("retry_end_msg", 32'(o_msg), 32'd3);
    go_idle();

    // exhaust retries
    en = 1; cyc(); send(4'd2);
    run_pt(16'h0000); run_pt(16'h0000);
    chk("exh_not_yet", 32'(o_msg), 32'd1);
    run_pt(16'h0000);
    chk("exh_end_msg", 32'(o_msg), 32'd3);
    chk("exh_pass", 32'(o_pass), 32'd0);
    chk("exh_retry", 32'(o_retry), 32'd2);
    chk("exh_lanes", 32'(o_lanes), 32'h0000);
    go_idle();

    // full mask passes on first run
    mask = 16'hFFFF;
    en = 1; cyc(); send(4'd2);
    run_pt(16'h0000);
    chk("mask_pass", 32'(o_pass), 32'd1);
    chk("mask_retry", 32'(o_retry), 32'd0);
    mask = 0;
    go_idle();

    // start timeout
    en = 1; cyc();
    repeat (TMO - 1) cyc();
    chk("tmo_pre", 32'(o_err), 32'd0);
    cyc();
    chk("tmo_err", 32'(o_err), 32'd1);
    chk("tmo_vtx", 32'(o_vtx), 32'd0);
    go_idle();

    // response on the final waiting cycle wins
    en = 1; cyc();
    repeat (TMO - 1) cyc();
    send(4'd2);
    chk("tmo_edge_err", 32'(o_err), 32'd0);
    chk("tmo_edge_pt", 32'(o_pt), 32'd1);

    // abort in CAL_ALGO
    en = 0; cyc();
    chk("abort_pt", 32'(o_pt), 32'd0);
    chk("abort_msg", 32'(o_msg), 32'd0);

    // reset during END_REQ
    en = 1; cyc(); send(4'd2); run_pt(16'h1234 | 16'hFFF0); run_pt(16'hFFFF); run_pt(16'hFFFF);
    chk("pre_rst_msg", 32'(o_msg), 32'd3);
    rst = 1; cyc(); rst = 0;
    chk("rst_mid_msg", 32'(o_msg), 32'd0);
    chk("rst_mid_lanes", 32'(o_lanes), 32'd0);
    chk("rst_mid_retry", 32'(o_retry), 32'd0);
    go_idle();

    // randomized traffic
    for (int i = 0; i < 6000; i++) begin
      rst  = ($urandom_range(0, 599) == 0);
      en   = ($urandom_range(0, 149) != 0);
      sv   = ($urandom_range(0, 2) == 0);
      msg  = 4'($urandom_range(0, 5));
      ack  = ($urandom_range(0, 3) == 0);
      busy = $urandom_range(0, 1) == 1;
      vrx  = $urandom_range(0, 1) == 1;
      case ($urandom_range(0, 3))
        0: res = 16'hFFFF;
        1: res = ~(16'h1 << $urandom_range(0, 15));
        default: res = 16'($urandom);
      endcase
      mask = ($urandom_range(0, 3) == 0) ? 16'($urandom) : 16'h0;
      cyc();
    end

    rst = 1; cyc(); rst = 0; en = 0; cyc();
    chk_on = 0;
    @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
